// File: rtl/mic_capture.sv
// PDM microphone capture: generates M_CLK, decimates the 1-bit stream into
// 8-bit unsigned samples and writes DEPTH consecutive words into BRAM.
module mic_capture #(
    parameter int CLK_DIV = 20,
    parameter int DECIM   = 256,
    parameter int DEPTH   = 81,
    parameter int ADDR_W  = 8
) (
    input  logic              CLK100MHZ,
    input  logic              reset,
    input  logic              start,
    input  logic              M_DATA,
    output logic              M_CLK,
    output logic              M_LRSEL,
    output logic              ena,
    output logic              wea,
    output logic [ADDR_W-1:0] addra,
    output logic [7:0]        dina,
    output logic              busy,
    output logic              done,
    output logic [2:0]        state_dbg
);

    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int SHIFT = 8 - $clog2(DECIM);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARM     = 3'd1,
        CAPTURE = 3'd2,
        WRITE   = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t            state;
    logic [DIV_W-1:0]  divcnt;
    logic              div_wrap;
    logic              tick;
    logic [8:0]        ones;
    logic [8:0]        bitcnt;
    logic [ADDR_W-1:0] addr;
    logic [8:0]        ones_next;
    logic [16:0]       scaled;
    logic [7:0]        sample;

    assign M_LRSEL   = 1'b0;
    assign state_dbg = state;
    assign div_wrap  = (divcnt == DIV_W'(CLK_DIV - 1));
    // A tick is the cycle on which M_CLK is about to fall; data is stable then.
    assign tick      = div_wrap && M_CLK;
    assign ones_next = ones + {8'd0, M_DATA};
    assign scaled    = {8'd0, ones_next} << SHIFT;
    assign sample    = (scaled > 17'd255) ? 8'hff : scaled[7:0];

    always_ff @(posedge CLK100MHZ) begin
        if (!reset) begin
            divcnt <= '0;
            M_CLK  <= 1'b0;
        end else if (div_wrap) begin
            divcnt <= '0;
            M_CLK  <= ~M_CLK;
        end else begin
            divcnt <= divcnt + 1'b1;
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        if (!reset) begin
            state  <= IDLE;
            ena    <= 1'b0;
            wea    <= 1'b0;
            addra  <= '0;
            dina   <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            addr   <= '0;
            ones   <= '0;
            bitcnt <= '0;
        end else begin
            ena  <= 1'b0;
            wea  <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= ARM;
                        busy  <= 1'b1;
                        addr  <= '0;
                    end
                end
                ARM: begin
                    if (tick) begin
                        ones   <= '0;
                        bitcnt <= '0;
                        state  <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (tick) begin
                        ones   <= ones_next;
                        bitcnt <= bitcnt + 9'd1;
                        // Last bit of the window is folded in directly so the
                        // write lands on the very next cycle.
                        if (bitcnt == 9'(DECIM - 1)) begin
                            state <= WRITE;
                            ena   <= 1'b1;
                            wea   <= 1'b1;
                            addra <= addr;
                            dina  <= sample;
                        end
                    end
                end
                WRITE: begin
                    if (addr == ADDR_W'(DEPTH - 1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        addr  <= '0;
                    end else begin
                        addr   <= addr + 1'b1;
                        ones   <= '0;
                        bitcnt <= '0;
                        state  <= CAPTURE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mic_capture.sv
// Directed bench for mic_capture with a shortened divider and window
// (CLK_DIV=2, DECIM=4) so whole captures stay short.
module tb_mic_capture;

    localparam int CLK_DIV = 2;
    localparam int DECIM   = 4;
    localparam int DEPTH   = 12;
    localparam int ADDR_W  = 8;

    logic              CLK100MHZ = 1'b0;
    logic              reset     = 1'b0;
    logic              start     = 1'b0;
    logic              M_DATA    = 1'b0;
    logic              M_CLK;
    logic              M_LRSEL;
    logic              ena;
    logic              wea;
    logic [ADDR_W-1:0] addra;
    logic [7:0]        dina;
    logic              busy;
    logic              done;
    logic [2:0]        state_dbg;

    int   checks = 0;
    int   errors = 0;
    bit   md_default = 1'b0;
    bit   pdm_q[$];

    mic_capture #(
        .CLK_DIV(CLK_DIV),
        .DECIM  (DECIM),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .CLK100MHZ(CLK100MHZ),
        .reset    (reset),
        .start    (start),
        .M_DATA   (M_DATA),
        .M_CLK    (M_CLK),
        .M_LRSEL  (M_LRSEL),
        .ena      (ena),
        .wea      (wea),
        .addra    (addra),
        .dina     (dina),
        .busy     (busy),
        .done     (done),
        .state_dbg(state_dbg)
    );

    always #5 CLK100MHZ = ~CLK100MHZ;

    // Microphone model: presents a new bit shortly after each M_CLK rise.
    always @(posedge M_CLK) begin
        #1;
        if (pdm_q.size() > 0) M_DATA = pdm_q.pop_front();
        else                  M_DATA = md_default;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Returns at the clk negedge just after M_CLK has fallen.
    task automatic sync_low();
        int   n = 0;
        logic prev;
        prev = M_CLK;
        do begin
            @(negedge CLK100MHZ);
            n++;
            if (prev && !M_CLK) break;
            prev = M_CLK;
        end while (n < 20);
        chk("sync_mclk_fall", 32'(n < 20), 32'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge CLK100MHZ);
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("state_arm", state_dbg, 1);
    endtask

    task automatic wait_write(input int exp_addr, input int exp_data, input int exp_gap);
        int n = 0;
        do begin
            @(negedge CLK100MHZ);
            n++;
        end while (!wea && n < 100);
        chk("write_gap", n, exp_gap);
        chk("addra", addra, exp_addr);
        chk("dina", dina, exp_data);
        chk("ena", ena, 1);
        chk("busy_in_write", busy, 1);
    endtask

    task automatic check_done();
        @(negedge CLK100MHZ);
        chk("done_pulse", done, 1);
        chk("busy_at_done", busy, 0);
        chk("wea_at_done", wea, 0);
        chk("state_done", state_dbg, 4);
        @(negedge CLK100MHZ);
        chk("done_cleared", done, 0);
        chk("state_idle", state_dbg, 0);
    endtask

    initial begin
        logic [15:0] mclk_seen;
        logic        lrsel_seen;
        int          exp_v[DEPTH];
        int          wea_seen;

        // Reset, with a start pulse that reset must override.
        repeat (2) @(negedge CLK100MHZ);
        start = 1'b1;
        @(negedge CLK100MHZ);
        start = 1'b0;
        chk("rst_mclk", M_CLK, 0);
        chk("rst_lrsel", M_LRSEL, 0);
        chk("rst_ena", ena, 0);
        chk("rst_wea", wea, 0);
        chk("rst_addra", addra, 0);
        chk("rst_dina", dina, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_state", state_dbg, 0);
        reset = 1'b1;

        // M_CLK: period 2*CLK_DIV, 50% duty, starting low after reset.
        lrsel_seen = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge CLK100MHZ);
            mclk_seen[i] = M_CLK;
            lrsel_seen   = lrsel_seen | M_LRSEL;
        end
        chk("mclk_wave", mclk_seen, 16'h6666);
        chk("lrsel_const", lrsel_seen, 0);
        chk("idle_busy", busy, 0);

        // All ones: every window saturates to 255.
        md_default = 1'b1;
        sync_low();
        pulse_start();
        for (int a = 0; a < DEPTH; a++) wait_write(a, 255, (a == 0) ? 19 : 16);
        check_done();

        // All zeros, with an extra start at the 5th write that must be ignored.
        md_default = 1'b0;
        sync_low();
        pulse_start();
        for (int a = 0; a < DEPTH; a++) begin
            wait_write(a, 0, (a == 0) ? 19 : (a == 5) ? 15 : 16);
            if (a == 4) begin
                start = 1'b1;
                @(negedge CLK100MHZ);
                start = 1'b0;
            end
        end
        check_done();

        // Alternating bits: two ones per window -> mid-scale 128.
        md_default = 1'b0;
        sync_low();
        pdm_q.push_back(1'b0);
        for (int i = 0; i < DEPTH * DECIM; i++) pdm_q.push_back(i % 2 == 0);
        pulse_start();
        for (int a = 0; a < DEPTH; a++) wait_write(a, 128, (a == 0) ? 19 : 16);
        check_done();

        // Window patterns 1000 / 1100 / 1111 -> 64, 128, 255 (clamped), then zeros.
        md_default = 1'b0;
        sync_low();
        pdm_q.push_back(1'b0);
        pdm_q.push_back(1'b1); pdm_q.push_back(1'b0); pdm_q.push_back(1'b0); pdm_q.push_back(1'b0);
        pdm_q.push_back(1'b1); pdm_q.push_back(1'b1); pdm_q.push_back(1'b0); pdm_q.push_back(1'b0);
        pdm_q.push_back(1'b1); pdm_q.push_back(1'b1); pdm_q.push_back(1'b1); pdm_q.push_back(1'b1);
        for (int a = 0; a < DEPTH; a++) exp_v[a] = 0;
        exp_v[0] = 64;
        exp_v[1] = 128;
        exp_v[2] = 255;
        pulse_start();
        for (int a = 0; a < DEPTH; a++) wait_write(a, exp_v[a], (a == 0) ? 19 : 16);
        check_done();

        // Reset during the window of sample 10: no write to address 10.
        md_default = 1'b1;
        sync_low();
        pulse_start();
        for (int a = 0; a < 10; a++) wait_write(a, 255, (a == 0) ? 19 : 16);
        wea_seen = 0;
        repeat (6) begin
            @(negedge CLK100MHZ);
            if (wea) wea_seen++;
        end
        chk("midwin_no_write", wea_seen, 0);
        reset = 1'b0;
        @(negedge CLK100MHZ);
        chk("midrst_wea", wea, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_addra", addra, 0);
        chk("midrst_state", state_dbg, 0);
        chk("midrst_done", done, 0);
        wea_seen = 0;
        repeat (2) begin
            @(negedge CLK100MHZ);
            if (wea) wea_seen++;
        end
        reset = 1'b1;
        repeat (20) begin
            @(negedge CLK100MHZ);
            if (wea) wea_seen++;
        end
        chk("midrst_no_write", wea_seen, 0);

        // Fresh capture after the aborted one starts again at address 0.
        sync_low();
        pulse_start();
        for (int a = 0; a < DEPTH; a++) wait_write(a, 255, (a == 0) ? 19 : 16);
        check_done();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mic_capture.md
# mic_capture

Records audio from the board's PDM microphone into block RAM, the write-side counterpart of the playback path that reads stored 8-bit samples from BRAM and sends them through the encode/decode/filter chain to the PWM output. The block generates the microphone clock and decimates the 1-bit PDM stream into 8-bit unsigned samples by counting ones per window. On a start pulse it fills DEPTH consecutive BRAM words, the same sample table the playback path reads, then reports done.

## Interface
Parameters:
- CLK_DIV, 20, M_CLK half-period in CLK100MHZ cycles (M_CLK = 2.5 MHz)
- DECIM, 256, PDM bits per output sample (power of two, 2..256)
- DEPTH, 81, samples written per capture (addresses 0..DEPTH-1)
- ADDR_W, 8, BRAM address width

Ports:
- CLK100MHZ  in  1  system clock, 100 MHz; the block's only clock
- reset  in  1  synchronous, active-low reset
- start  in  1  single-cycle pulse (debounced) that begins a capture
- M_DATA  in  1  PDM data from microphone
- M_CLK  out  1  microphone clock, registered
- M_LRSEL  out  1  constant 0 (left channel, data valid after M_CLK rise)
- ena  out  1  BRAM port enable
- wea  out  1  BRAM write enable
- addra  out  ADDR_W  BRAM address
- dina  out  8  BRAM write data
- busy  out  1  high from start acceptance until the final write
- done  out  1  one-cycle pulse after the final write

## Operation
- Clock divider: counter divcnt runs 0..CLK_DIV-1 continuously, including in IDLE. M_CLK toggles when divcnt = CLK_DIV-1. Period is 2*CLK_DIV cycles.
- Sample tick: asserted on the cycle M_CLK toggles 1→0. M_DATA is registered on that edge.
- States:
  - IDLE: outputs quiescent. start=1 → ARM, busy=1, addr=0.
  - ARM: wait for the next tick. The accumulator is cleared, then the state goes to CAPTURE. That tick's bit is not counted.
  - CAPTURE: on each tick, ones += M_DATA and bitcnt += 1. When bitcnt reaches DECIM → WRITE.
  - WRITE: exactly one cycle. ena=1, wea=1, addra=addr, dina=sat(ones * 256/DECIM).
    - If addr = DEPTH-1 → DONE.
    - Otherwise addr += 1, ones=0, bitcnt=0, and the state returns to CAPTURE.
  - DONE: one cycle. done=1, busy=0, addr=0 → IDLE.
- Arithmetic:
  - ones is a 9-bit counter.
  - The scaled value is ones shifted left by log2(256/DECIM).
  - sat() clamps to 255, so a count of 256 with DECIM=256 writes 255.
  - The output is unsigned, with 128 as mid-scale.
- Boundary conditions:
  - start while busy is ignored.
  - start and reset asserted together: reset wins.
  - Reset mid-capture:
    - Next edge: state=IDLE and wea=0, so the partial sample is discarded and no write happens.
    - Next edge: addr=0 and divcnt=0.
    - Words already written stay in BRAM.
  - A WRITE cycle can never coincide with a tick, because ticks are ≥2 cycles apart and WRITE lasts 1 cycle. No PDM bit is lost between windows.

## Timing
- Reset values:
  - M_CLK=0, M_LRSEL=0, ena=0, wea=0, addra=0, dina=0, busy=0, done=0.
  - State IDLE, divcnt=0.
- Outside WRITE: ena=0, wea=0. addra and dina hold their last written values.
- start accepted on the edge where it is sampled high. busy rises the following cycle.
- ARM lasts 1..2*CLK_DIV cycles, until the next tick.
- Each sample window is DECIM ticks, i.e. DECIM*2*CLK_DIV cycles (10240 with defaults).
- WRITE occurs on the cycle after the DECIM-th tick of the window.
- done pulses the cycle after the last WRITE. busy falls on that same cycle.
- Capture sample rate with defaults: 100e6/(40*256) ≈ 9766 Hz.
- Total capture time: ARM + DEPTH*DECIM*2*CLK_DIV + 1 cycles.

## Test plan
- M_CLK check: after reset release, M_CLK has a 40-cycle period, 50% duty. M_LRSEL=0 throughout.
- Constant input: M_DATA=1, start pulse → 81 writes at addra 0..80, each dina=255 (saturation), writes spaced 10240 cycles apart. Then one done pulse and busy=0. Repeat with M_DATA=0 → all dina=0.
- Alternating input: M_DATA alternating 1/0 per tick → every dina=128.
- Reduced window: with DECIM=4 and window bit patterns 1,0,0,0 / 1,1,0,0 / 1,1,1,1 → dina=64, 128, 255. This checks scaling and the clamp.
- Ignored start: a start pulse at the 5th write while busy → no restart, and addra sequence stays continuous.
- Reset mid-capture: reset low during the window of sample 10, M_DATA=1 → wea=0 from the next cycle, no write to address 10, busy=0, addra=0. A new start then writes from address 0.
